// File: rtl/packet_sink_if.sv
// Bundles the stream input, capture read port and result outputs of packet_sink.
// Latency: none; this is wiring only.
// Backpressure: none; the stream has no ready, the sink consumes every strobed word.
interface packet_sink_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CAP_AW     = 6,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  strobe;
    logic                  last;
    logic                  arm;
    logic [CAP_AW-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic                  pkt_done;
    logic [CNT_WIDTH-1:0]  pkt_len;
    logic [DATA_WIDTH-1:0] pkt_sum;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic [CNT_WIDTH-1:0]  drop_count;
    logic                  cap_full;
    logic                  len_err;

    // Stream source / debug reader side
    modport master (
        output data, strobe, last, arm, rd_addr,
        input  rd_data, busy, pkt_done, pkt_len, pkt_sum,
        input  pkt_count, drop_count, cap_full, len_err
    );

    // Sink side
    modport slave (
        input  data, strobe, last, arm, rd_addr,
        output rd_data, busy, pkt_done, pkt_len, pkt_sum,
        output pkt_count, drop_count, cap_full, len_err
    );
endinterface

// File: rtl/packet_sink.sv
// Test-harness stream sink: captures packet head into RAM, reports length/checksum/error flags.
// Latency: pkt_done/pkt_len/pkt_sum one cycle after the last beat; rd_data one cycle after rd_addr.
// Backpressure: none; every strobed word is consumed, words outside a packet are dropped and counted.
module packet_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int CAP_AW     = 6,
    parameter int MAX_WORDS  = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int ONESHOT    = 1
) (
    input  logic         clk,
    input  logic         rst,
    packet_sink_if.slave sink
);
    localparam int                   DEPTH     = 1 << CAP_AW;
    localparam logic [CNT_WIDTH-1:0] CAP_DEPTH = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] MAX_LEN   = CNT_WIDTH'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_IN_PKT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [DATA_WIDTH-1:0] sum_inc;
    logic                  collecting, take, pkt_end, drop, start, wr_en;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  pkt_done_q, cap_full_q, len_err_q;
    logic [CNT_WIDTH-1:0]  pkt_len_q, pkt_count_q, drop_count_q;
    logic [DATA_WIDTH-1:0] pkt_sum_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; a last beat ends in DONE or re-arms depending on ONESHOT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (sink.arm) state_d = S_ARMED;
            S_ARMED, S_IN_PKT: begin
                if (sink.strobe) begin
                    if (sink.last) state_d = (ONESHOT != 0) ? S_DONE : S_ARMED;
                    else           state_d = S_IN_PKT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Beat qualification, write enable and running count/sum next values
    always_comb begin
        collecting = (state_q == S_ARMED) || (state_q == S_IN_PKT);
        take       = collecting && sink.strobe;
        pkt_end    = take && sink.last;
        drop       = !collecting && sink.strobe;
        start      = !collecting && sink.arm;
        wr_en      = take && (cnt_q < CAP_DEPTH);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        sum_inc    = sum_q + sink.data;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        if (start || pkt_end) begin
            cnt_d = '0;
            sum_d = '0;
        end else if (take) begin
            cnt_d = cnt_inc;
            sum_d = sum_inc;
        end
    end

    // Running accumulators and per-packet results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            sum_q        <= '0;
            pkt_done_q   <= 1'b0;
            pkt_len_q    <= '0;
            pkt_sum_q    <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            cap_full_q   <= 1'b0;
            len_err_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            pkt_done_q <= pkt_end;
            rd_data_q  <= mem[sink.rd_addr];
            if (pkt_end) begin
                pkt_len_q   <= cnt_inc;
                pkt_sum_q   <= sum_inc;
                pkt_count_q <= pkt_count_q + 1'b1;
                if (cnt_inc > MAX_LEN) len_err_q <= 1'b1;
            end
            if (take && !wr_en) cap_full_q <= 1'b1;
            if (drop && (drop_count_q != '1)) drop_count_q <= drop_count_q + 1'b1;
        end
    end

    // Capture RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q[CAP_AW-1:0]] <= sink.data;
    end

    assign sink.busy       = collecting;
    assign sink.rd_data    = rd_data_q;
    assign sink.pkt_done   = pkt_done_q;
    assign sink.pkt_len    = pkt_len_q;
    assign sink.pkt_sum    = pkt_sum_q;
    assign sink.pkt_count  = pkt_count_q;
    assign sink.drop_count = drop_count_q;
    assign sink.cap_full   = cap_full_q;
    assign sink.len_err    = len_err_q;
endmodule
